out_ram_arbiter: RTL and testbench

//  Shares the two ports of the 512x16 output dual-port RAM among NUM_REQ requesters (attention output

---
 rtl/out_ram_arbiter_if.sv | 32 +++
 rtl/out_ram_arbiter.sv | 103 ++++++++++
 tb/tb_out_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/out_ram_arbiter_if.sv
// out_ram_arbiter_if: requester handshake, read response and dual-port RAM signals for out_ram_arbiter
interface out_ram_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*AWIDTH-1:0] req_addr;
  logic [NUM_REQ*DWIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DWIDTH-1:0] rsp_data;
  logic [AWIDTH-1:0]         ram_address_a;
  logic                      ram_wren_a;
  logic [DWIDTH-1:0]         ram_data_a;
  logic [DWIDTH-1:0]         ram_out_a;
  logic [AWIDTH-1:0]         ram_address_b;
  logic                      ram_wren_b;
  logic [DWIDTH-1:0]         ram_data_b;
  logic [DWIDTH-1:0]         ram_out_b;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_out_a, ram_out_b,
    input  req_ready, rsp_valid, rsp_data,
    input  ram_address_a, ram_wren_a, ram_data_a, ram_address_b, ram_wren_b, ram_data_b
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_out_a, ram_out_b,
    output req_ready, rsp_valid, rsp_data,
    output ram_address_a, ram_wren_a, ram_data_a, ram_address_b, ram_wren_b, ram_data_b
  );
endinterface

// File: rtl/out_ram_arbiter.sv
// out_ram_arbiter: round-robin sharing of the two output-RAM ports, up to two grants per cycle
module out_ram_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 16
) (
  input logic clk,
  input logic reset,
  out_ram_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  logic [AWIDTH-1:0]  addr [NUM_REQ];
  logic [DWIDTH-1:0]  wdata [NUM_REQ];
  logic [IW-1:0]      rr_ptr, nxt_ptr, j, ia, ib;
  logic               has_a, has_b, we_a, we_b;
  logic [NUM_REQ-1:0] ready, rsp_valid_q;
  logic [AWIDTH-1:0]  ram_addr_a, ram_addr_b;
  logic [DWIDTH-1:0]  ram_wd_a, ram_wd_b;
  logic               ram_we_a, ram_we_b;
  logic               t1_va, t1_vb, t2_va, t2_vb;
  logic [IW-1:0]      t1_ia, t1_ib, t2_ia, t2_ib;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr[g]  = bus.req_addr[g*AWIDTH +: AWIDTH];
    assign wdata[g] = bus.req_wdata[g*DWIDTH +: DWIDTH];
    assign bus.rsp_data[g*DWIDTH +: DWIDTH] = (t2_va && t2_ia == IW'(g)) ? bus.ram_out_a :
                                              (t2_vb && t2_ib == IW'(g)) ? bus.ram_out_b : '0;
  end
  // A reader and a writer (or two writers) of one address never share a cycle
  always_comb begin
    has_a = 1'b0;
    has_b = 1'b0;
    ia = '0;
    ib = '0;
    j = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[j]) begin
        if (!has_a) begin
          has_a = 1'b1;
          ia = j;
        end else if (!has_b && !(addr[j] == addr[ia] && (bus.req_we[j] || bus.req_we[ia]))) begin
          has_b = 1'b1;
          ib = j;
        end
      end
    end
    we_a = has_a & bus.req_we[ia];
    we_b = has_b & bus.req_we[ib];
    ready = '0;
    if (has_a) ready[ia] = 1'b1;
    if (has_b) ready[ib] = 1'b1;
    nxt_ptr = IW'((int'(has_b ? ib : ia) + 1) % NUM_REQ);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_wd_a <= '0;
      ram_wd_b <= '0;
      ram_we_a <= 1'b0;
      ram_we_b <= 1'b0;
      t1_va <= 1'b0;
      t1_vb <= 1'b0;
      t2_va <= 1'b0;
      t2_vb <= 1'b0;
      t1_ia <= '0;
      t1_ib <= '0;
      t2_ia <= '0;
      t2_ib <= '0;
      rsp_valid_q <= '0;
    end else begin
      if (has_a) rr_ptr <= nxt_ptr;
      ram_we_a <= we_a;
      ram_we_b <= we_b;
      if (has_a) begin
        ram_addr_a <= addr[ia];
        ram_wd_a <= wdata[ia];
      end
      if (has_b) begin
        ram_addr_b <= addr[ib];
        ram_wd_b <= wdata[ib];
      end
      t1_va <= has_a & ~we_a;
      t1_vb <= has_b & ~we_b;
      t1_ia <= ia;
      t1_ib <= ib;
      t2_va <= t1_va;
      t2_vb <= t1_vb;
      t2_ia <= t1_ia;
      t2_ib <= t1_ib;
      rsp_valid_q <= (NUM_REQ'(t1_va) << t1_ia) | (NUM_REQ'(t1_vb) << t1_ib);
    end
  end
  assign bus.req_ready     = ready;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.ram_address_a = ram_addr_a;
  assign bus.ram_wren_a    = ram_we_a;
  assign bus.ram_data_a    = ram_wd_a;
  assign bus.ram_address_b = ram_addr_b;
  assign bus.ram_wren_b    = ram_we_b;
  assign bus.ram_data_b    = ram_wd_b;
endmodule

// File: tb/tb_out_ram_arbiter.sv
// tb_out_ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_out_ram_arbiter;
  localparam int N = 4, AW = 9, DW = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0, checks = 0;
  logic [DW-1:0] mem [512];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;
  out_ram_arbiter_if #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) bus ();
  out_ram_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // Dual-port RAM with registered read data (old data on read-during-write)
  always @(posedge clk) begin
    if (bus.ram_wren_a) mem[bus.ram_address_a] <= bus.ram_data_a;
    if (bus.ram_wren_b) mem[bus.ram_address_b] <= bus.ram_data_b;
    if (pre_we) mem[pre_a] <= pre_d;
    bus.ram_out_a <= mem[bus.ram_address_a];
    bus.ram_out_b <= mem[bus.ram_address_b];
  end
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_we[i] = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_a = a;
    pre_d = d;
    pre_we = 1'b1;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask
  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    bus.req_valid = '0;
    next_cycle();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    mid();
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    checks++; if ({bus.ram_wren_a, bus.ram_wren_b} !== 2'b00) begin errors++; $display("FAIL reset_wren got=%b exp=00", {bus.ram_wren_a, bus.ram_wren_b}); end
    checks++; if ({bus.ram_address_a, bus.ram_address_b} !== 18'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", {bus.ram_address_a, bus.ram_address_b}); end
    checks++; if ({bus.ram_data_a, bus.ram_data_b} !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {bus.ram_data_a, bus.ram_data_b}); end
    next_cycle();
    reset = 1'b0;
  endtask
  task automatic test_write_read();
    next_cycle(); set_req(0, 1, 1, 9'h005, 16'h3C00); mid();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL wr_ready got=%b exp=0001", bus.req_ready); end
    next_cycle(); set_req(0, 0, 0, 0, 0); mid();
    checks++; if ({bus.ram_wren_a, bus.ram_wren_b} !== 2'b10) begin errors++; $display("FAIL wr_wren got=%b exp=10", {bus.ram_wren_a, bus.ram_wren_b}); end
    checks++; if (bus.ram_address_a !== 9'h005) begin errors++; $display("FAIL wr_addr got=%h exp=005", bus.ram_address_a); end
    checks++; if (bus.ram_data_a !== 16'h3C00) begin errors++; $display("FAIL wr_data got=%h exp=3c00", bus.ram_data_a); end
    next_cycle(); set_req(1, 1, 0, 9'h005, 0); mid();
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rd_ready got=%b exp=0010", bus.req_ready); end
    next_cycle(); set_req(1, 0, 0, 0, 0); mid();
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rd_early got=%b exp=0000", bus.rsp_valid); end
    next_cycle(); mid();
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL rd_valid got=%b exp=0010", bus.rsp_valid); end
    checks++; if (bus.rsp_data[DW +: DW] !== 16'h3C00) begin errors++; $display("FAIL rd_data got=%h exp=3c00", bus.rsp_data[DW +: DW]); end
  endtask
  task automatic test_all_read();
    logic [DW-1:0] v [N];
    logic [N-1:0] er, ev;
    for (int i = 0; i < N; i++) begin v[i] = DW'($urandom); preload(AW'(100 + i), v[i]); end
    do_reset();
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) set_req(i, c < 4, 0, AW'(100 + i), 0);
      mid();
      er = (c >= 4) ? 4'b0000 : (c % 2 == 1) ? 4'b1100 : 4'b0011;
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL all_ready c=%0d got=%b exp=%b", c, bus.req_ready, er); end
      if (c >= 2) begin
        ev = (c % 2 == 1) ? 4'b1100 : 4'b0011;
        checks++; if (bus.rsp_valid !== ev) begin errors++; $display("FAIL all_rsp_valid c=%0d got=%b exp=%b", c, bus.rsp_valid, ev); end
        for (int i = 0; i < N; i++)
          if (ev[i]) begin
            checks++; if (bus.rsp_data[i*DW +: DW] !== v[i]) begin errors++; $display("FAIL all_rsp_data c=%0d id=%0d got=%h exp=%h", c, i, bus.rsp_data[i*DW +: DW], v[i]); end
          end
      end
    end
  endtask
  task automatic test_conflict();
    preload(9'd10, 16'h1111);
    do_reset();
    next_cycle(); set_req(0, 1, 1, 9'd10, 16'hBEEF); set_req(1, 1, 0, 9'd10, 0); mid();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL cf_ready0 got=%b exp=0001", bus.req_ready); end
    next_cycle(); set_req(0, 0, 0, 0, 0); mid();
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL cf_ready1 got=%b exp=0010", bus.req_ready); end
    next_cycle(); set_req(1, 0, 0, 0, 0); mid();
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL cf_early got=%b exp=0000", bus.rsp_valid); end
    next_cycle(); mid();
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL cf_valid got=%b exp=0010", bus.rsp_valid); end
    checks++; if (bus.rsp_data[DW +: DW] !== 16'hBEEF) begin errors++; $display("FAIL cf_data got=%h exp=beef", bus.rsp_data[DW +: DW]); end
  endtask
  task automatic test_same_addr_reads();
    logic [DW-1:0] x;
    x = DW'($urandom);
    preload(9'd7, x);
    next_cycle(); set_req(2, 1, 0, 9'd7, 0); set_req(3, 1, 0, 9'd7, 0); mid();
    checks++; if (bus.req_ready !== 4'b1100) begin errors++; $display("FAIL sa_ready got=%b exp=1100", bus.req_ready); end
    next_cycle(); set_req(2, 0, 0, 0, 0); set_req(3, 0, 0, 0, 0);
    next_cycle(); mid();
    checks++; if (bus.rsp_valid !== 4'b1100) begin errors++; $display("FAIL sa_valid got=%b exp=1100", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== {x, x, 32'h0}) begin errors++; $display("FAIL sa_data got=%h exp=%h", bus.rsp_data, {x, x, 32'h0}); end
  endtask
  task automatic test_single_requester();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      next_cycle(); set_req(3, 1, 1, AW'(200 + k), DW'(k)); mid();
      checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL single_ready k=%0d got=%b exp=1000", k, bus.req_ready); end
      if (k > 0) begin
        checks++; if ({bus.ram_wren_a, bus.ram_wren_b} !== 2'b10) begin errors++; $display("FAIL single_wren k=%0d got=%b exp=10", k, {bus.ram_wren_a, bus.ram_wren_b}); end
      end
    end
    next_cycle();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(100 + i), 0);
    mid();
    checks++; if (bus.req_ready !== 4'b0011) begin errors++; $display("FAIL single_rr got=%b exp=0011", bus.req_ready); end
    checks++; if ({bus.ram_wren_a, bus.ram_wren_b, bus.ram_address_a} !== {2'b10, 9'd204}) begin errors++; $display("FAIL single_last got=%b/%0d exp=10/204", {bus.ram_wren_a, bus.ram_wren_b}, bus.ram_address_a); end
    next_cycle(); bus.req_valid = '0;
    next_cycle(); next_cycle();
  endtask
  task automatic test_reset_mid_read();
    do_reset();
    next_cycle(); set_req(0, 1, 0, 9'h005, 0); mid();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rst_ready got=%b exp=0001", bus.req_ready); end
    next_cycle(); set_req(0, 0, 0, 0, 0); reset = 1'b1; mid();
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_valid0 got=%b exp=0000", bus.rsp_valid); end
    checks++; if ({bus.ram_wren_a, bus.ram_address_a, bus.ram_address_b} !== 19'h0) begin errors++; $display("FAIL rst_ram got=%h exp=0", {bus.ram_wren_a, bus.ram_address_a, bus.ram_address_b}); end
    next_cycle(); mid();
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_valid1 got=%b exp=0000", bus.rsp_valid); end
    next_cycle(); reset = 1'b0; mid();
    checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_valid2 got=%b exp=0000", bus.rsp_valid); end
    next_cycle(); set_req(1, 1, 0, 9'h005, 0); mid();
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rst_after_ready got=%b exp=0010", bus.req_ready); end
    next_cycle(); set_req(1, 0, 0, 0, 0);
    next_cycle(); mid();
    checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data[DW +: DW] !== 16'h3C00) begin errors++; $display("FAIL rst_after_rsp got=%b/%h exp=0010/3c00", bus.rsp_valid, bus.rsp_data[DW +: DW]); end
  endtask
  task automatic test_random();
    logic [DW-1:0] ref_mem [8];
    logic pv [N];
    logic pwe [N];
    logic [2:0] pa [N];
    logic [DW-1:0] pd [N];
    logic [DW-1:0] e0_d [N];
    logic [DW-1:0] e1_d [N];
    logic [N-1:0] e0_v, e1_v, er;
    logic [DW-1:0] xd;
    int rr, ga, gb, i, g;
    for (int a = 0; a < 8; a++) begin ref_mem[a] = DW'($urandom); preload(AW'(a), ref_mem[a]); end
    for (int q = 0; q < N; q++) pv[q] = 1'b0;
    e0_v = '0;
    e1_v = '0;
    rr = 0;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      next_cycle();
      for (int q = 0; q < N; q++) begin
        if (!pv[q] && $urandom_range(3) != 0) begin
          pv[q] = 1'b1;
          pwe[q] = ($urandom_range(2) == 0);
          pa[q] = 3'($urandom_range(7));
          pd[q] = DW'($urandom);
        end
        set_req(q, pv[q], pwe[q], AW'(pa[q]), pd[q]);
      end
      mid();
      ga = -1;
      gb = -1;
      for (int k = 0; k < N; k++) begin
        i = (rr + k) % N;
        if (pv[i]) begin
          if (ga < 0) ga = i;
          else if (gb < 0 && !(pa[i] == pa[ga] && (pwe[i] || pwe[ga]))) gb = i;
        end
      end
      er = '0;
      if (ga >= 0) er[ga] = 1'b1;
      if (gb >= 0) er[gb] = 1'b1;
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, er); end
      checks++; if (bus.rsp_valid !== e0_v) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, e0_v); end
      for (int q = 0; q < N; q++) begin
        xd = e0_v[q] ? e0_d[q] : '0;
        checks++; if (bus.rsp_data[q*DW +: DW] !== xd) begin errors++; $display("FAIL rnd_rsp_data cyc=%0d id=%0d got=%h exp=%h", cyc, q, bus.rsp_data[q*DW +: DW], xd); end
      end
      checks++;
      if (bus.ram_wren_a && bus.ram_wren_b && bus.ram_address_a == bus.ram_address_b) begin errors++; $display("FAIL rnd_dual_write cyc=%0d addr=%0d", cyc, bus.ram_address_a); end
      e0_v = e1_v;
      e0_d = e1_d;
      e1_v = '0;
      for (int s = 0; s < 2; s++) begin
        g = (s == 0) ? ga : gb;
        if (g >= 0 && !pwe[g]) begin e1_v[g] = 1'b1; e1_d[g] = ref_mem[pa[g]]; end
      end
      for (int s = 0; s < 2; s++) begin
        g = (s == 0) ? ga : gb;
        if (g >= 0) begin
          if (pwe[g]) ref_mem[pa[g]] = pd[g];
          pv[g] = 1'b0;
        end
      end
      if (ga >= 0) rr = ((gb >= 0 ? gb : ga) + 1) % N;
    end
    next_cycle();
    bus.req_valid = '0;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
    test_reset();
    test_write_read();
    test_all_read();
    test_conflict();
    test_same_addr_reads();
    test_single_requester();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
